// File: rtl/ultra_ram_stream_port_if.sv
// ultra_ram_stream_port_if: request and response streams between a client
// and the front end of one UltraRAM port.
interface ultra_ram_stream_port_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 512
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/ultra_ram_stream_port.sv
// ultra_ram_stream_port: credit-gated request front end and response FIFO for one UltraRAM port.
// Define ULTRA_RAM_STREAM_PORT_RANGE_CHECK_EN to drop out-of-range accesses and raise err_range.
module ultra_ram_stream_port #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 512,
  parameter int DEPTH        = 49152,
  parameter int READ_LATENCY = 1,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  ultra_ram_stream_port_if.slave bus,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_di,
  input  logic [DATA_WIDTH-1:0]  mem_do,
  output logic                   err_range
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RESP_DEPTH - 1);

  if (DEPTH < 1 || READ_LATENCY < 1 ||
      RESP_DEPTH < READ_LATENCY + 2) begin : g_bad_cfg
    $error("ultra_ram_stream_port: illegal parameter set");
  end

  logic [CW-1:0]           r_out;
  logic [CW-1:0]           r_cnt;
  logic [PW-1:0]           r_wptr;
  logic [PW-1:0]           r_rptr;
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_oor;
  logic [DATA_WIDTH-1:0]   r_fifo [RESP_DEPTH];

  logic                  w_ready;
  logic                  w_fire;
  logic                  w_rd;
  logic                  w_oor;
  logic                  w_en;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_push_data;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

`ifdef ULTRA_RAM_STREAM_PORT_RANGE_CHECK_EN
  logic r_err;
  assign w_oor = 32'(bus.req_addr) >= DEPTH;
  assign err_range = r_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_fire && w_oor) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_oor = 1'b0;
  assign err_range = 1'b0;
`endif

  // Credits cover every read still owed to the consumer, so the FIFO never overflows
  assign w_ready = !reset && (r_out < FULL);
  assign w_fire  = bus.req_valid && w_ready;
  assign w_rd    = w_fire && !bus.req_write;
  assign w_en    = w_fire && !w_oor;

  assign mem_en   = w_en;
  assign mem_we   = w_en && bus.req_write;
  assign mem_addr = w_fire ? bus.req_addr : '0;
  assign mem_di   = w_fire ? bus.req_data : '0;

  assign w_push      = r_vld[READ_LATENCY-1];
  assign w_push_data = r_oor[READ_LATENCY-1] ? '0 : mem_do;
  assign w_valid     = (r_cnt != '0);
  assign w_pop       = w_valid && bus.resp_ready;

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = w_valid;
  assign bus.resp_data  = w_valid ? r_fifo[r_rptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld <= '0;
      r_oor <= '0;
    end else begin
      r_vld[0] <= w_rd;
      r_oor[0] <= w_rd && w_oor;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_oor[i] <= r_oor[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= nxt(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= nxt(r_rptr);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_out <= r_out + CW'(w_rd) - CW'(w_pop);
    end
  end
endmodule
